// File: rtl/bp_common_pkg.sv
// bp_common_pkg: shared types for the performance counter bank.
package bp_common_pkg;

  typedef enum logic [1:0] {
    e_perf_warmup = 2'd0,
    e_perf_run    = 2'd1,
    e_perf_done   = 2'd2
  } bp_perf_state_e;

endpackage

// File: rtl/bp_nonsynth_perf_sat_counter.sv
// bp_nonsynth_perf_sat_counter: saturating event counter with sticky overflow.
module bp_nonsynth_perf_sat_counter #(
  parameter int width_p = 64
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               en_i,
  input  logic               inc_i,
  input  logic               clear_i,
  output logic [width_p-1:0] cnt_o,
  output logic [width_p-1:0] cnt_n_o,
  output logic               ovf_o
);
  logic full, step;
  assign full = &cnt_o;
  assign step = en_i & inc_i & ~clear_i;
  // overflow marks a dropped increment, so reaching all-ones exactly is not flagged
  assign cnt_n_o = clear_i ? '0 : (step & ~full) ? cnt_o + width_p'(1) : cnt_o;
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cnt_o <= '0;
      ovf_o <= 1'b0;
    end else begin
      cnt_o <= cnt_n_o;
      ovf_o <= ~clear_i & (ovf_o | (step & full));
    end
  end
endmodule

// File: rtl/bp_nonsynth_perf_bank.sv
// bp_nonsynth_perf_bank: warmup/windowed clock, instruction and event counters with snapshots.
module bp_nonsynth_perf_bank
  import bp_common_pkg::*;
#(
  parameter int num_events_p   = 4,
  parameter int cnt_width_p    = 64,
  parameter int warmup_width_p = 32
) (
  input  logic                                clk_i,
  input  logic                                reset_n_i,
  input  logic                                freeze_i,
  input  logic                                clear_i,
  input  logic                                debug_mode_i,
  input  logic [warmup_width_p-1:0]           warmup_instr_i,
  input  logic [cnt_width_p-1:0]              window_instr_i,
  input  logic                                commit_v_i,
  input  logic [num_events_p-1:0]             event_v_i,
  input  logic                                snapshot_i,
  output logic [1:0]                          state_o,
  output logic [cnt_width_p-1:0]              clk_cnt_o,
  output logic [cnt_width_p-1:0]              instr_cnt_o,
  output logic [num_events_p*cnt_width_p-1:0] event_cnt_o,
  output logic [cnt_width_p-1:0]              snap_clk_o,
  output logic [cnt_width_p-1:0]              snap_instr_o,
  output logic [num_events_p*cnt_width_p-1:0] snap_event_o,
  output logic                                snap_v_o,
  output logic                                done_o,
  output logic [num_events_p+1:0]             ovf_o
);
  localparam int n_cnt = num_events_p + 2;
  bp_perf_state_e state_q, state_n;
  logic [warmup_width_p-1:0] warm_q, warm_n;
  logic [n_cnt-1:0][cnt_width_p-1:0] cnt, cnt_n, snap_q;
  logic [n_cnt-1:0] inc;
  logic restart, running, warm_hit, complete, take_snap;
  assign restart   = freeze_i | clear_i;
  assign running   = (state_q == e_perf_run) & ~debug_mode_i;
  assign inc       = {event_v_i, commit_v_i, 1'b1};
  assign warm_n    = (state_q == e_perf_warmup && !debug_mode_i && commit_v_i && !(&warm_q))
                   ? warm_q + warmup_width_p'(1) : warm_q;
  // leave warmup on the commit that reaches the threshold, or at once when it is already met
  assign warm_hit  = (warm_q == warmup_instr_i) || (warm_n == warmup_instr_i);
  assign complete  = (state_q == e_perf_run) && !restart && (window_instr_i != '0)
                   && (cnt_n[1] == window_instr_i);
  assign take_snap = (state_q == e_perf_run) && !restart && snapshot_i;
  always_comb
    state_n = restart ? e_perf_warmup
            : complete ? e_perf_done
            : (state_q == e_perf_warmup && warm_hit) ? e_perf_run : state_q;
  for (genvar i = 0; i < n_cnt; i++) begin : g_cnt
    bp_nonsynth_perf_sat_counter #(.width_p(cnt_width_p)) u_cnt (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .en_i      (running),
      .inc_i     (inc[i]),
      .clear_i   (restart),
      .cnt_o     (cnt[i]),
      .cnt_n_o   (cnt_n[i]),
      .ovf_o     (ovf_o[i])
    );
  end
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q  <= e_perf_warmup;
      warm_q   <= '0;
      snap_q   <= '0;
      done_o   <= 1'b0;
      snap_v_o <= 1'b0;
    end else begin
      state_q  <= state_n;
      warm_q   <= restart ? '0 : warm_n;
      snap_q   <= complete ? cnt_n : take_snap ? cnt : snap_q;
      done_o   <= complete;
      snap_v_o <= complete | take_snap;
    end
  end
  assign state_o      = state_q;
  assign clk_cnt_o    = cnt[0];
  assign instr_cnt_o  = cnt[1];
  assign event_cnt_o  = cnt[n_cnt-1:2];
  assign snap_clk_o   = snap_q[0];
  assign snap_instr_o = snap_q[1];
  assign snap_event_o = snap_q[n_cnt-1:2];
endmodule

// File: doc/bp_nonsynth_perf_bank.md
BP_NONSYNTH_PERF_BANK -- requirements
Module: bp_nonsynth_perf_bank

Interface
REQ-001 SHALL have parameter num_events_p, default 4, number of independent event channels (>=1).
REQ-002 SHALL have parameter cnt_width_p, default 64, width of every clock/instruction/event counter.
REQ-003 SHALL have parameter warmup_width_p, default 32, width of the warmup counter and threshold.
REQ-004 SHALL have port clk_i, input, 1, the single clock.
REQ-005 SHALL have port reset_n_i, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port freeze_i, input, 1, core frozen; forces a restart of measurement.
REQ-007 SHALL have port clear_i, input, 1, software restart of measurement.
REQ-008 SHALL have port debug_mode_i, input, 1, pauses all counting while high.
REQ-009 SHALL have port warmup_instr_i, input, warmup_width_p, commits to skip before measuring.
REQ-010 SHALL have port window_instr_i, input, cnt_width_p, measured-instruction window length; 0 = unbounded.
REQ-011 SHALL have port commit_v_i, input, 1, one instruction retired this cycle.
REQ-012 SHALL have port event_v_i, input, num_events_p, per-channel event strobe (e.g. dcache hit, miss).
REQ-013 SHALL have port snapshot_i, input, 1, request copy of live counters into snapshot registers.
REQ-014 SHALL have port state_o, output, 2, current state encoding.
REQ-015 SHALL have port clk_cnt_o / instr_cnt_o, output, cnt_width_p each, live counters.
REQ-016 SHALL have port event_cnt_o, output, num_events_p*cnt_width_p, live event counters, channel 0 in LSBs.
REQ-017 SHALL have port snap_clk_o, snap_instr_o, snap_event_o, output, same widths, snapshot registers.
REQ-018 SHALL have port snap_v_o, output, 1, one-cycle pulse when snapshot registers were written.
REQ-019 SHALL have port done_o, output, 1, one-cycle pulse on window completion.
REQ-020 SHALL have port ovf_o, output, num_events_p+2, sticky saturation flags {events, instr, clk}.

Function
REQ-021 SHALL implement states WARMUP, RUN, DONE.
REQ-022 WARMUP SHALL increment the warmup counter by commit_v_i when debug_mode_i is low; live counters stay 0.
REQ-023 WARMUP SHALL go to RUN on the cycle the warmup counter equals warmup_instr_i (warmup_instr_i=0: RUN in first post-reset cycle); counting starts the following cycle.
REQ-024 RUN with debug_mode_i low SHALL add 1 to clk_cnt, commit_v_i to instr_cnt, event_v_i[i] to event_cnt[i] each cycle.
REQ-025 RUN with debug_mode_i high SHALL hold all counters (pause, not clear).
REQ-026 RUN SHALL go to DONE when window_instr_i!=0 and the post-increment instr_cnt equals window_instr_i; that cycle's increments SHALL be included.
REQ-027 Entering DONE SHALL write the final counter values into snapshot registers and pulse done_o and snap_v_o in the first DONE cycle.
REQ-028 DONE SHALL hold all counters and snapshots until clear_i or freeze_i.
REQ-029 snapshot_i in RUN SHALL copy pre-increment live values into snapshots and pulse snap_v_o next cycle; ignored in WARMUP and DONE.
REQ-030 freeze_i or clear_i (any state) SHALL, next cycle, enter WARMUP with warmup, live counters and ovf_o zeroed; snapshots SHALL be retained.
REQ-031 Priority SHALL be freeze_i/clear_i > window completion > snapshot_i > counting.
REQ-032 Each counter SHALL saturate at all-ones and set its ovf_o bit, sticky until clear/freeze/reset.
REQ-033 Warmup counter SHALL saturate at all-ones, never wrapping.

Reset
REQ-034 reset_n_i low SHALL asynchronously set state WARMUP and all counters, snapshots, ovf_o, done_o, snap_v_o to 0.
REQ-035 Reset deassertion SHALL be synchronized by the instantiator; the block SHALL be glitch-free on the first post-reset edge.

Structure
REQ-036 State enum bp_perf_state_e SHALL live in bp_common_pkg.
REQ-037 A sub-module bp_nonsynth_perf_sat_counter (width, enable, increment, clear, saturate, sticky overflow) SHALL be instantiated num_events_p+2 times.

Verification
REQ-038 warmup=3, window=0, 5 commits then idle 4 cycles -> RUN after 3rd commit; instr_cnt=2, clk_cnt counts every RUN cycle.
REQ-039 warmup=0, window=4, commit every cycle -> done_o pulses once, snap_instr_o=4, counters frozen thereafter.
REQ-040 RUN, debug_mode_i high 10 cycles with commits -> no counter changes; resume continues from held values.
REQ-041 cnt_width_p=4, 20 event_v_i[1] pulses -> event_cnt[1]=15, ovf_o bit set; clear_i -> 0, flag cleared.
REQ-042 Assert reset_n_i mid-RUN between edges -> all outputs 0 immediately, state WARMUP.
REQ-043 snapshot_i and window completion same cycle -> single snap_v_o, snapshot holds completion values.
